bus_initiator: RTL and testbench

BUS_INITIATOR -- requirements
Module: bus_initiator

---
 rtl/bus_initiator_if.sv | 44 ++++
 rtl/bus_initiator.sv | 118 +++++++++++
 tb/tb_bus_initiator.sv | 265 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/bus_initiator_if.sv
// Core request/response and single-beat bus signals for bus_initiator.
// The master modport is the initiator's view; slave is the core/bus-agent view.
interface bus_initiator_if;
    logic        req_valid;
    logic        req_ready;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        req_we;
    logic [3:0]  req_be;

    logic        resp_valid;
    logic [31:0] resp_rdata;
    logic        resp_error;

    logic [31:0] bus_addrData_o;
    logic [3:0]  bus_byteEnables_o;
    logic [7:0]  bus_burstSize_o;
    logic        bus_readNWrite_o;
    logic        bus_beginTransaction_o;
    logic        bus_endTransaction_o;
    logic        bus_dataValid_o;

    logic [31:0] bus_addrData_i;
    logic        bus_endTransaction_i;
    logic        bus_dataValid_i;
    logic        bus_busy_i;
    logic        bus_error_i;

    modport master (
        input  req_valid, req_addr, req_wdata, req_we, req_be,
        output req_ready, resp_valid, resp_rdata, resp_error,
        output bus_addrData_o, bus_byteEnables_o, bus_burstSize_o, bus_readNWrite_o,
        output bus_beginTransaction_o, bus_endTransaction_o, bus_dataValid_o,
        input  bus_addrData_i, bus_endTransaction_i, bus_dataValid_i, bus_busy_i, bus_error_i
    );

    modport slave (
        output req_valid, req_addr, req_wdata, req_we, req_be,
        input  req_ready, resp_valid, resp_rdata, resp_error,
        input  bus_addrData_o, bus_byteEnables_o, bus_burstSize_o, bus_readNWrite_o,
        input  bus_beginTransaction_o, bus_endTransaction_o, bus_dataValid_o,
        output bus_addrData_i, bus_endTransaction_i, bus_dataValid_i, bus_busy_i, bus_error_i
    );
endinterface

// File: rtl/bus_initiator.sv
// Single-beat bus initiator: accepts one core request, runs an ADDR/DATA
// bus transaction with a wait-cycle timeout, and returns a one-cycle response.
//
// state  | meaning
// IDLE   | ready for a core request
// ADDR   | one cycle, address phase with beginTransaction
// DATA   | waiting for slave completion (write data driven), timeout counting
// RESP   | one-cycle resp_valid pulse
module bus_initiator #(
    parameter int unsigned TIMEOUT_CYCLES = 16
) (
    input  logic            clk,
    input  logic            rst_n,
    bus_initiator_if.master bif
);
    typedef enum logic [1:0] {S_IDLE, S_ADDR, S_DATA, S_RESP} state_t;

    // Timeout fires on the DATA cycle that would bring the count to TIMEOUT_CYCLES.
    localparam logic [7:0] TIMEOUT_LAST = 8'(TIMEOUT_CYCLES - 1);

    state_t      state;
    logic [31:0] addr_q;
    logic [31:0] wdata_q;
    logic        we_q;
    logic [3:0]  be_q;
    logic [7:0]  wait_cnt;
    logic [31:0] rdata_cap;
    logic [31:0] resp_rdata_q;
    logic        resp_error_q;

    logic done_ok;
    logic timeout_hit;

    assign done_ok     = bif.bus_endTransaction_i && !bif.bus_busy_i;
    assign timeout_hit = (wait_cnt == TIMEOUT_LAST);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= S_IDLE;
            addr_q       <= '0;
            wdata_q      <= '0;
            we_q         <= 1'b0;
            be_q         <= '0;
            wait_cnt     <= '0;
            rdata_cap    <= '0;
            resp_rdata_q <= '0;
            resp_error_q <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (bif.req_valid) begin
                        addr_q  <= bif.req_addr;
                        wdata_q <= bif.req_wdata;
                        we_q    <= bif.req_we;
                        be_q    <= bif.req_be;
                        state   <= S_ADDR;
                    end
                end
                S_ADDR: begin
                    wait_cnt  <= '0;
                    rdata_cap <= '0;
                    state     <= S_DATA;
                end
                S_DATA: begin
                    if (!we_q && bif.bus_dataValid_i)
                        rdata_cap <= bif.bus_addrData_i;
                    if (done_ok) begin
                        state        <= S_RESP;
                        resp_error_q <= bif.bus_error_i;
                        if (we_q || bif.bus_error_i)
                            resp_rdata_q <= '0;
                        else if (bif.bus_dataValid_i)
                            resp_rdata_q <= bif.bus_addrData_i;
                        else
                            resp_rdata_q <= rdata_cap;
                    end else if (timeout_hit) begin
                        state        <= S_RESP;
                        resp_error_q <= 1'b1;
                        resp_rdata_q <= '0;
                    end else begin
                        wait_cnt <= wait_cnt + 8'd1;
                    end
                end
                S_RESP: state <= S_IDLE;
                default: state <= S_IDLE;
            endcase
        end
    end

    assign bif.req_ready  = (state == S_IDLE);
    assign bif.resp_valid = (state == S_RESP);
    assign bif.resp_rdata = resp_rdata_q;
    assign bif.resp_error = resp_error_q;

    assign bif.bus_burstSize_o        = 8'd0;
    assign bif.bus_beginTransaction_o = (state == S_ADDR);
    assign bif.bus_endTransaction_o   = (state == S_DATA) && we_q;
    assign bif.bus_dataValid_o        = (state == S_DATA) && we_q;

    always_comb begin
        bif.bus_addrData_o    = '0;
        bif.bus_byteEnables_o = '0;
        bif.bus_readNWrite_o  = 1'b1;
        case (state)
            S_ADDR: begin
                bif.bus_addrData_o    = addr_q;
                bif.bus_byteEnables_o = be_q;
                bif.bus_readNWrite_o  = ~we_q;
            end
            S_DATA: begin
                bif.bus_addrData_o    = we_q ? wdata_q : 32'd0;
                bif.bus_byteEnables_o = be_q;
                bif.bus_readNWrite_o  = ~we_q;
            end
            default: ;
        endcase
    end
endmodule

// File: tb/tb_bus_initiator.sv
// Directed and randomized transactions against bus_initiator, checked with a
// transaction-level model of completion, timeout and read-data capture.
module tb_bus_initiator;
    localparam int TMO  = 16;
    localparam int MAXC = 24;

    logic clk   = 1'b0;
    logic rst_n = 1'b1;
    always #5 clk = ~clk;

    bus_initiator_if bif ();

    bus_initiator #(.TIMEOUT_CYCLES(TMO)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bif   (bif)
    );

    int n_assert = 0;
    int n_fail   = 0;

    // Slave behaviour per DATA cycle of the next transaction.
    logic        s_end  [MAXC];
    logic        s_busy [MAXC];
    logic        s_err  [MAXC];
    logic        s_dv   [MAXC];
    logic [31:0] s_data [MAXC];

    task automatic chk32(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic chk1(input string tag, input logic obs, input logic exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %b expected %b", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic slave_noise();
        bif.bus_addrData_i       = $urandom;
        bif.bus_endTransaction_i = 1'($urandom_range(0, 1));
        bif.bus_dataValid_i      = 1'($urandom_range(0, 1));
        bif.bus_busy_i           = 1'($urandom_range(0, 1));
        bif.bus_error_i          = 1'($urandom_range(0, 1));
    endtask

    task automatic slave_quiet();
        bif.bus_addrData_i       = '0;
        bif.bus_endTransaction_i = 1'b0;
        bif.bus_dataValid_i      = 1'b0;
        bif.bus_busy_i           = 1'b0;
        bif.bus_error_i          = 1'b0;
    endtask

    task automatic clear_slave();
        for (int i = 0; i < MAXC; i++) begin
            s_end[i]  = 1'b0;
            s_busy[i] = 1'b0;
            s_err[i]  = 1'b0;
            s_dv[i]   = 1'b0;
            s_data[i] = '0;
        end
    endtask

    task automatic random_slave();
        clear_slave();
        if ($urandom_range(0, 5) != 0) begin
            for (int i = 0; i < MAXC; i++) begin
                s_end[i]  = ($urandom_range(0, 2) == 0);
                s_busy[i] = ($urandom_range(0, 2) == 0);
                s_err[i]  = ($urandom_range(0, 5) == 0);
                s_dv[i]   = ($urandom_range(0, 2) == 0);
                s_data[i] = $urandom;
            end
        end
    endtask

    // Outcome of a transaction: number of DATA cycles spent, error flag, read data.
    function automatic void model(input logic we, output int n_data,
                                  output logic err, output logic [31:0] rdata);
        int k = -1;
        for (int i = 0; i < TMO; i++)
            if (k < 0 && s_end[i] && !s_busy[i]) k = i;
        rdata = '0;
        if (k < 0) begin
            n_data = TMO;
            err    = 1'b1;
        end else begin
            n_data = k + 1;
            err    = s_err[k];
            if (!we && !err)
                for (int i = 0; i <= k; i++)
                    if (s_dv[i]) rdata = s_data[i];
        end
    endfunction

    task automatic run_txn(input string tag, input logic we, input logic [31:0] addr,
                           input logic [31:0] wdata, input logic [3:0] be);
        int          n_data;
        logic        e_err;
        logic [31:0] e_rdata;
        model(we, n_data, e_err, e_rdata);

        chk1({tag, ".idle_ready"}, bif.req_ready, 1'b1);
        bif.req_valid = 1'b1;
        bif.req_addr  = addr;
        bif.req_wdata = wdata;
        bif.req_we    = we;
        bif.req_be    = be;
        slave_noise();
        step();

        // ADDR: request fields scrambled to prove they were latched
        bif.req_valid = 1'($urandom_range(0, 1));
        bif.req_addr  = $urandom;
        bif.req_wdata = $urandom;
        bif.req_we    = 1'($urandom_range(0, 1));
        bif.req_be    = 4'($urandom);
        slave_noise();
        chk1 ({tag, ".addr_begin"}, bif.bus_beginTransaction_o, 1'b1);
        chk32({tag, ".addr_data"}, bif.bus_addrData_o, addr);
        chk32({tag, ".addr_be"}, 32'(bif.bus_byteEnables_o), 32'(be));
        chk1 ({tag, ".addr_rnw"}, bif.bus_readNWrite_o, ~we);
        chk1 ({tag, ".addr_ready"}, bif.req_ready, 1'b0);
        chk1 ({tag, ".addr_dvo"}, bif.bus_dataValid_o, 1'b0);
        step();

        for (int i = 0; i < n_data; i++) begin
            chk1 ({tag, ".data_begin"}, bif.bus_beginTransaction_o, 1'b0);
            chk32({tag, ".data_ad"}, bif.bus_addrData_o, we ? wdata : 32'd0);
            chk1 ({tag, ".data_dvo"}, bif.bus_dataValid_o, we);
            chk1 ({tag, ".data_endo"}, bif.bus_endTransaction_o, we);
            chk1 ({tag, ".data_rvalid"}, bif.resp_valid, 1'b0);
            if (i == 0) begin
                chk32({tag, ".data_be"}, 32'(bif.bus_byteEnables_o), 32'(be));
                chk1 ({tag, ".data_rnw"}, bif.bus_readNWrite_o, ~we);
                chk32({tag, ".data_burst"}, 32'(bif.bus_burstSize_o), 32'd0);
            end
            bif.req_valid            = 1'($urandom_range(0, 1));
            bif.bus_endTransaction_i = s_end[i];
            bif.bus_busy_i           = s_busy[i];
            bif.bus_error_i          = s_err[i];
            bif.bus_dataValid_i      = s_dv[i];
            bif.bus_addrData_i       = s_data[i];
            step();
        end

        bif.req_valid = 1'b0;
        slave_noise();
        chk1 ({tag, ".resp_valid"}, bif.resp_valid, 1'b1);
        chk32({tag, ".resp_rdata"}, bif.resp_rdata, e_rdata);
        chk1 ({tag, ".resp_error"}, bif.resp_error, e_err);
        chk32({tag, ".resp_ad"}, bif.bus_addrData_o, 32'd0);
        chk1 ({tag, ".resp_rnw"}, bif.bus_readNWrite_o, 1'b1);
        chk1 ({tag, ".resp_dvo"}, bif.bus_dataValid_o, 1'b0);
        step();

        chk1 ({tag, ".post_valid"}, bif.resp_valid, 1'b0);
        chk1 ({tag, ".post_ready"}, bif.req_ready, 1'b1);
        chk32({tag, ".post_rdata"}, bif.resp_rdata, e_rdata);
        chk1 ({tag, ".post_error"}, bif.resp_error, e_err);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        bif.req_valid = 1'b0;
        bif.req_addr  = '0;
        bif.req_wdata = '0;
        bif.req_we    = 1'b0;
        bif.req_be    = '0;
        slave_quiet();
        clear_slave();

        #2 rst_n = 1'b0;
        #1;
        chk1 ("rst.ready", bif.req_ready, 1'b1);
        chk1 ("rst.valid", bif.resp_valid, 1'b0);
        chk32("rst.rdata", bif.resp_rdata, 32'd0);
        chk1 ("rst.error", bif.resp_error, 1'b0);
        chk1 ("rst.begin", bif.bus_beginTransaction_o, 1'b0);
        chk1 ("rst.rnw", bif.bus_readNWrite_o, 1'b1);
        chk32("rst.ad", bif.bus_addrData_o, 32'd0);
        chk32("rst.be", 32'(bif.bus_byteEnables_o), 32'd0);
        step();
        step();
        rst_n = 1'b1;
        step();

        clear_slave();
        s_end[0] = 1'b1;
        run_txn("wr_zero_wait", 1'b1, 32'h00F0_0000, 32'h0000_00A5, 4'hF);

        clear_slave();
        s_end[0] = 1'b1; s_dv[0] = 1'b1; s_data[0] = 32'h0000_0031;
        run_txn("rd_zero_wait", 1'b0, 32'h00F0_0008, 32'h1234_5678, 4'hF);

        // Reset while in DATA abandons the transfer
        chk1("mid.ready", bif.req_ready, 1'b1);
        bif.req_valid = 1'b1;
        bif.req_addr  = 32'h0000_1000;
        bif.req_we    = 1'b0;
        bif.req_be    = 4'h3;
        slave_quiet();
        step();
        bif.req_valid = 1'b0;
        step();
        step();
        chk1("mid.in_data", bif.req_ready, 1'b0);
        rst_n = 1'b0;
        #1;
        chk1 ("mid.rst_ready", bif.req_ready, 1'b1);
        chk1 ("mid.rst_valid", bif.resp_valid, 1'b0);
        chk32("mid.rst_rdata", bif.resp_rdata, 32'd0);
        chk1 ("mid.rst_rnw", bif.bus_readNWrite_o, 1'b1);
        chk32("mid.rst_be", 32'(bif.bus_byteEnables_o), 32'd0);
        step();
        rst_n = 1'b1;
        step();
        chk1("mid.post_ready", bif.req_ready, 1'b1);
        chk1("mid.post_valid", bif.resp_valid, 1'b0);
        step();
        chk1("mid.post_valid2", bif.resp_valid, 1'b0);

        clear_slave();
        for (int i = 0; i < 4; i++) s_end[i] = 1'b1;
        for (int i = 0; i < 3; i++) s_busy[i] = 1'b1;
        run_txn("busy3", 1'b1, 32'h0000_0040, 32'hCAFE_F00D, 4'h5);

        clear_slave();
        run_txn("timeout", 1'b0, 32'h0000_0080, 32'h0, 4'hF);

        clear_slave();
        s_end[0] = 1'b1; s_dv[0] = 1'b1; s_err[0] = 1'b1; s_data[0] = 32'hDEAD_BEEF;
        run_txn("rd_error", 1'b0, 32'h0000_00C0, 32'h0, 4'hF);

        clear_slave();
        s_end[TMO-1] = 1'b1; s_dv[2] = 1'b1; s_data[2] = 32'h0BAD_CAFE;
        run_txn("complete_at_limit", 1'b0, 32'h0000_0100, 32'h0, 4'hC);

        for (int t = 0; t < 30; t++) begin
            random_slave();
            run_txn($sformatf("rand%0d", t), 1'($urandom_range(0, 1)), $urandom, $urandom,
                    4'($urandom));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule
